// File: rtl/led_cmd_parser.sv
// led_cmd_parser: takes ASCII LED commands from a UART RX FIFO, echoes every
// accepted byte back to the UART transmitter, and holds nine 8-bit colour
// levels (three LEDs x R/G/B) for the WS2812 driver.
//
// Commands: <colour><led>LF toggles a channel; <colour><led>=<hex><hex>LF sets
// a level. CR is echoed and otherwise ignored anywhere in a command.
//
// state     | meaning
// ----------|--------------------------------------------------------
// IDLE      | between commands, waiting for a colour letter
// COLOUR    | colour letter seen, expecting LED digit 1..3
// NUMBER    | colour and LED seen, expecting LF (toggle) or '='
// HEX_HI    | expecting upper hex digit of the level
// HEX_LO    | expecting lower hex digit of the level
// EXPECT_LF | level complete, expecting LF to commit the write
// DISCARD   | malformed command, swallowing bytes up to the next LF

module led_cmd_parser #(
  parameter logic [7:0] DEFAULT_LEVEL  = 8'h11,
  parameter int         TIMEOUT_CYCLES = 8000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       i_Data_Ready,
  input  logic [7:0] i_Data,
  output logic       o_Read_Data,
  input  logic       i_TX_Busy,
  output logic       o_TX_Start,
  output logic [7:0] o_TX_Data,
  output logic [7:0] o_LED1_R,
  output logic [7:0] o_LED1_G,
  output logic [7:0] o_LED1_B,
  output logic [7:0] o_LED2_R,
  output logic [7:0] o_LED2_G,
  output logic [7:0] o_LED2_B,
  output logic [7:0] o_LED3_R,
  output logic [7:0] o_LED3_G,
  output logic [7:0] o_LED3_B,
  output logic       o_Update,
  output logic       o_Error
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; expiry is detected there.
  localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit                TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_G  = 8'h67;
  localparam logic [7:0] CH_B  = 8'h62;

  typedef enum logic [2:0] {
    IDLE,
    COLOUR,
    NUMBER,
    HEX_HI,
    HEX_LO,
    EXPECT_LF,
    DISCARD
  } state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             accept_q;
  logic [1:0]       colour_q, colour_d;
  logic [1:0]       led_q, led_d;
  logic [3:0]       hi_q, hi_d;
  logic [3:0]       lo_q, lo_d;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;
  logic             wr_en;
  logic [7:0]       wr_val;
  logic             err;
  logic             update_q;
  logic [7:0]       lvl_q [9];
  logic [3:0]       sel_idx;
  logic [7:0]       cur_level;

  logic             is_colour;
  logic [1:0]       colour_code;
  logic             is_led;
  logic [1:0]       led_code;
  logic             hex_ok;
  logic [3:0]       hex_nib;

  // Accept a byte when one is waiting, the echo path is free and we did not
  // accept last cycle; reset masks it so the FIFO is never popped in reset.
  always_comb begin
    accept = ~Reset & i_Data_Ready & ~i_TX_Busy & ~accept_q;
  end

  // Remember the accept so the following cycle is a mandatory pause.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) accept_q <= 1'b0;
    else       accept_q <= accept;
  end

  // Character classification of the FIFO head byte.
  always_comb begin
    is_colour   = 1'b1;
    colour_code = 2'd0;
    case (i_Data)
      CH_R:    colour_code = 2'd0;
      CH_G:    colour_code = 2'd1;
      CH_B:    colour_code = 2'd2;
      default: is_colour = 1'b0;
    endcase

    is_led   = (i_Data >= 8'h31) && (i_Data <= 8'h33);
    led_code = i_Data[1:0] - 2'd1;

    hex_ok  = 1'b1;
    hex_nib = i_Data[3:0];
    if ((i_Data >= 8'h30) && (i_Data <= 8'h39)) begin
      hex_nib = i_Data[3:0];
    end else if (((i_Data >= 8'h61) && (i_Data <= 8'h66)) ||
                 ((i_Data >= 8'h41) && (i_Data <= 8'h46))) begin
      hex_nib = i_Data[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  // Register selected by the latched colour/LED pair: LED-major, R/G/B minor.
  always_comb begin
    sel_idx   = ({2'b00, led_q} * 4'd3) + {2'b00, colour_q};
    cur_level = lvl_q[sel_idx];
  end

  // Expiry fires only in a cycle without an accept, so an accept always wins.
  always_comb begin
    tmo_hit = TMO_EN && (state_q != IDLE) && !accept && (tmo_cnt_q == TMO_LAST);
  end

  // Parser state and command field latches.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      colour_q <= 2'd0;
      led_q    <= 2'd0;
      hi_q     <= 4'd0;
      lo_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
      led_q    <= led_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state decode, register write requests and error pulses.
  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    led_d    = led_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    wr_en    = 1'b0;
    wr_val   = 8'h00;
    err      = 1'b0;

    if (accept && (i_Data != CH_CR)) begin
      case (state_q)
        IDLE: begin
          if (is_colour) begin
            colour_d = colour_code;
            state_d  = COLOUR;
          end else if (i_Data == CH_LF) begin
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end
        COLOUR: begin
          if (is_led) begin
            led_d   = led_code;
            state_d = NUMBER;
          end else if (i_Data == CH_LF) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end
        NUMBER: begin
          if (i_Data == CH_LF) begin
            wr_en   = 1'b1;
            wr_val  = (cur_level != 8'h00) ? 8'h00 : DEFAULT_LEVEL;
            state_d = IDLE;
          end else if (i_Data == CH_EQ) begin
            state_d = HEX_HI;
          end else begin
            state_d = DISCARD;
          end
        end
        HEX_HI: begin
          if (hex_ok) begin
            hi_d    = hex_nib;
            state_d = HEX_LO;
          end else if (i_Data == CH_LF) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end
        HEX_LO: begin
          if (hex_ok) begin
            lo_d    = hex_nib;
            state_d = EXPECT_LF;
          end else if (i_Data == CH_LF) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end
        EXPECT_LF: begin
          if (i_Data == CH_LF) begin
            wr_en   = 1'b1;
            wr_val  = {hi_q, lo_q};
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end
        DISCARD: begin
          if (i_Data == CH_LF) begin
            err     = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      err     = 1'b1;
      state_d = IDLE;
    end
  end

  // Inactivity timer: cleared by any accept and while idle, counts otherwise.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tmo_cnt_q <= '0;
    end else if (!TMO_EN || accept || (state_q == IDLE) || tmo_hit) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end

  // Colour level registers; o_Update follows every write by one cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 9; i++) lvl_q[i] <= 8'h00;
      update_q <= 1'b0;
    end else begin
      update_q <= wr_en;
      if (wr_en) lvl_q[sel_idx] <= wr_val;
    end
  end

  assign o_Read_Data = accept;
  assign o_TX_Start  = accept;
  assign o_TX_Data   = accept ? i_Data : 8'h00;
  assign o_Error     = err;
  assign o_Update    = update_q;

  assign o_LED1_R = lvl_q[0];
  assign o_LED1_G = lvl_q[1];
  assign o_LED1_B = lvl_q[2];
  assign o_LED2_R = lvl_q[3];
  assign o_LED2_G = lvl_q[4];
  assign o_LED2_B = lvl_q[5];
  assign o_LED3_R = lvl_q[6];
  assign o_LED3_G = lvl_q[7];
  assign o_LED3_B = lvl_q[8];

endmodule

// File: tb/tb_led_cmd_parser.sv
// Testbench for led_cmd_parser: a command table with fixed expectations,
// hand-written multi-cycle sequences, and randomized traffic, all checked
// every cycle against a line-oriented reference model.

module tb_led_cmd_parser;

  localparam int         TMO = 50;
  localparam logic [7:0] DEF = 8'h11;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       i_Data_Ready = 1'b0;
  logic [7:0] i_Data = 8'h00;
  logic       i_TX_Busy = 1'b0;
  logic       o_Read_Data, o_TX_Start, o_Update, o_Error;
  logic [7:0] o_TX_Data;
  logic [7:0] o_LED1_R, o_LED1_G, o_LED1_B;
  logic [7:0] o_LED2_R, o_LED2_G, o_LED2_B;
  logic [7:0] o_LED3_R, o_LED3_G, o_LED3_B;

  always #5 Clock = ~Clock;

  led_cmd_parser #(.DEFAULT_LEVEL(DEF), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .Reset(Reset),
    .i_Data_Ready(i_Data_Ready), .i_Data(i_Data), .o_Read_Data(o_Read_Data),
    .i_TX_Busy(i_TX_Busy), .o_TX_Start(o_TX_Start), .o_TX_Data(o_TX_Data),
    .o_LED1_R(o_LED1_R), .o_LED1_G(o_LED1_G), .o_LED1_B(o_LED1_B),
    .o_LED2_R(o_LED2_R), .o_LED2_G(o_LED2_G), .o_LED2_B(o_LED2_B),
    .o_LED3_R(o_LED3_R), .o_LED3_G(o_LED3_G), .o_LED3_B(o_LED3_B),
    .o_Update(o_Update), .o_Error(o_Error)
  );

  logic [7:0] led_out [9];
  assign led_out[0] = o_LED1_R;
  assign led_out[1] = o_LED1_G;
  assign led_out[2] = o_LED1_B;
  assign led_out[3] = o_LED2_R;
  assign led_out[4] = o_LED2_G;
  assign led_out[5] = o_LED2_B;
  assign led_out[6] = o_LED3_R;
  assign led_out[7] = o_LED3_G;
  assign led_out[8] = o_LED3_B;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // stimulus FIFO and busy control
  byte unsigned rx_q[$];
  bit           busy_drv  = 1'b0;
  bit           rand_busy = 1'b0;

  // reference model: current partial line, idle time, pending update
  logic [7:0]   m_led [9];
  byte unsigned m_line[$];
  int           m_idle;
  bit           m_prev_acc;
  bit           m_upd;

  // observations of the DUT
  int           seen_err, seen_upd, seen_rd;
  byte unsigned echo_q[$];
  int           rd_cyc[$];

  typedef struct {
    string      cmd;
    int         idx;
    logic [7:0] val;
    int         errs;
    int         upds;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int colour_of(input byte unsigned c);
    if (c == 8'h72) return 0;
    if (c == 8'h67) return 1;
    if (c == 8'h62) return 2;
    return -1;
  endfunction

  function automatic int led_of(input byte unsigned c);
    if (c >= 8'h31 && c <= 8'h33) return int'(c) - 8'h31;
    return -1;
  endfunction

  function automatic int hex_of(input byte unsigned c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 8'h30;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 8'h61 + 10;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 8'h41 + 10;
    return -1;
  endfunction

  // Judge a complete line (CRs already stripped): 1 = write, 0 = error.
  function automatic bit parse_line(output logic [3:0] idx, output logic [7:0] val);
    int c, l, h, lo;
    idx = 4'd0;
    val = 8'h00;
    if (m_line.size() != 2 && m_line.size() != 5) return 1'b0;
    c = colour_of(m_line[0]);
    l = led_of(m_line[1]);
    if (c < 0 || l < 0) return 1'b0;
    idx = 4'(l * 3 + c);
    if (m_line.size() == 2) begin
      val = (m_led[idx] != 8'h00) ? 8'h00 : DEF;
      return 1'b1;
    end
    if (m_line[2] != 8'h3D) return 1'b0;
    h  = hex_of(m_line[3]);
    lo = hex_of(m_line[4]);
    if (h < 0 || lo < 0) return 1'b0;
    val = 8'(h * 16 + lo);
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_led[i] = 8'h00;
    m_line.delete();
    m_idle     = 0;
    m_prev_acc = 1'b0;
    m_upd      = 1'b0;
  endtask

  task automatic clear_obs();
    seen_err = 0;
    seen_upd = 0;
    seen_rd  = 0;
    echo_q.delete();
    rd_cyc.delete();
  endtask

  // One clock: drive, compare at the falling edge, then advance the model.
  task automatic run_cycle();
    logic        acc, exp_err, wr;
    logic [3:0]  widx;
    logic [7:0]  wval, b;
    logic [71:0] exp_leds, act_leds;
    if (rand_busy) busy_drv = ($urandom_range(0, 3) == 0);
    i_Data_Ready = (rx_q.size() > 0);
    i_Data       = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    i_TX_Busy    = busy_drv;
    @(negedge Clock);
    b       = i_Data;
    acc     = i_Data_Ready && !i_TX_Busy && !m_prev_acc;
    exp_err = 1'b0;
    wr      = 1'b0;
    widx    = 4'd0;
    wval    = 8'h00;
    if (acc) begin
      m_idle = 0;
      if (b == 8'h0A) begin
        if (m_line.size() > 0) begin
          if (parse_line(widx, wval)) wr = 1'b1;
          else exp_err = 1'b1;
          m_line.delete();
        end
      end else if (b != 8'h0D) begin
        m_line.push_back(b);
      end
    end else if (m_line.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        exp_err = 1'b1;
        m_line.delete();
        m_idle = 0;
      end
    end
    for (int i = 0; i < 9; i++) begin
      exp_leds[i*8 +: 8] = m_led[i];
      act_leds[i*8 +: 8] = led_out[i];
    end
    check("strobes", {o_Read_Data, o_TX_Start, o_TX_Data, o_Error, o_Update},
          {acc, acc, (acc ? b : 8'h00), exp_err, m_upd});
    check("leds", act_leds, exp_leds);
    if (o_Error)     seen_err++;
    if (o_Update)    seen_upd++;
    if (o_TX_Start)  echo_q.push_back(o_TX_Data);
    if (o_Read_Data) begin
      seen_rd++;
      rd_cyc.push_back(cyc);
    end
    if (wr) m_led[widx] = wval;
    m_upd      = wr;
    m_prev_acc = acc;
    if (acc) void'(rx_q.pop_front());
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    logic [71:0] act_leds;
    Reset = 1'b1;
    rx_q.delete();
    busy_drv  = 1'b0;
    rand_busy = 1'b0;
    model_clear();
    i_Data_Ready = 1'b1;
    i_Data       = 8'h62;
    i_TX_Busy    = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    for (int i = 0; i < 9; i++) act_leds[i*8 +: 8] = led_out[i];
    check("reset_outputs", {o_Read_Data, o_TX_Start, o_TX_Data, o_Error, o_Update, act_leds}, '0);
    i_Data_Ready = 1'b0;
    i_Data       = 8'h00;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic send(input string s, input int drain);
    int n;
    clear_obs();
    for (int i = 0; i < s.len(); i++) rx_q.push_back(8'(s[i]));
    n = 0;
    while (rx_q.size() > 0 && n < 2000) begin
      run_cycle();
      n++;
    end
    check("fifo_drain", rx_q.size(), 0);
    rx_q.delete();
    repeat (drain) run_cycle();
  endtask

  task automatic set_vec(input int i, input string c, input int idx, input logic [7:0] v,
                         input int e, input int u);
    tbl[i].cmd  = c;
    tbl[i].idx  = idx;
    tbl[i].val  = v;
    tbl[i].errs = e;
    tbl[i].upds = u;
  endtask

  function automatic byte unsigned hex_char(input int v, input bit upper);
    if (v < 10) return 8'(8'h30 + v);
    return 8'((upper ? 8'h41 : 8'h61) + v - 10);
  endfunction

  // Push one random command (valid, malformed or partial) into the FIFO.
  task automatic gen_cmd(input int kind);
    byte unsigned colours [3];
    byte unsigned pool [14];
    colours = '{8'h72, 8'h67, 8'h62};
    pool    = '{8'h72, 8'h67, 8'h62, 8'h31, 8'h32, 8'h33, 8'h3D, 8'h30,
                8'h61, 8'h46, 8'h78, 8'h0D, 8'h34, 8'h0A};
    if (kind <= 3) begin
      rx_q.push_back(colours[$urandom_range(0, 2)]);
      if ($urandom_range(0, 5) == 0) rx_q.push_back(8'h0D);
      rx_q.push_back(8'(8'h31 + $urandom_range(0, 2)));
      rx_q.push_back(8'h0A);
    end else if (kind <= 6) begin
      rx_q.push_back(colours[$urandom_range(0, 2)]);
      rx_q.push_back(8'(8'h31 + $urandom_range(0, 2)));
      rx_q.push_back(8'h3D);
      rx_q.push_back(hex_char($urandom_range(0, 15), 1'($urandom_range(0, 1))));
      if ($urandom_range(0, 5) == 0) rx_q.push_back(8'h0D);
      rx_q.push_back(hex_char($urandom_range(0, 15), 1'($urandom_range(0, 1))));
      rx_q.push_back(8'h0A);
    end else if (kind == 7) begin
      repeat ($urandom_range(1, 6)) rx_q.push_back(pool[$urandom_range(0, 13)]);
      rx_q.push_back(8'h0A);
    end else if (kind == 8) begin
      rx_q.push_back(colours[$urandom_range(0, 2)]);
      if ($urandom_range(0, 1) == 1) rx_q.push_back(8'(8'h31 + $urandom_range(0, 2)));
    end else begin
      rx_q.push_back(($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int kind;
    bit ok;

    set_vec(0,  "r1\n",             0, 8'h11, 0, 1);
    set_vec(1,  "r1\n",             0, 8'h00, 0, 1);
    set_vec(2,  "b3=A5\n",          8, 8'hA5, 0, 1);
    set_vec(3,  "g2=0f\015\n",      4, 8'h0F, 0, 1);
    set_vec(4,  "x1\n",             3, 8'h00, 1, 0);
    set_vec(5,  "g1\n",             1, 8'h11, 0, 1);
    set_vec(6,  "r3=zz\n",          6, 8'h00, 1, 0);
    set_vec(7,  "\n",               0, 8'h00, 0, 0);
    set_vec(8,  "b1=\n",            2, 8'h00, 1, 0);
    set_vec(9,  "r2=7F\n",          3, 8'h7F, 0, 1);
    set_vec(10, "r2\n",             3, 8'h00, 0, 1);
    set_vec(11, "G1\n",             1, 8'h11, 1, 0);
    set_vec(12, "g1=Ab\n",          1, 8'hAB, 0, 1);
    set_vec(13, "b3=A5\n",          8, 8'hA5, 0, 1);
    set_vec(14, "\015r\0152\015\n", 3, 8'h11, 0, 1);

    do_reset();

    // command table, applied back to back from reset
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].cmd, 3);
      check("tbl_level",   led_out[tbl[i].idx], tbl[i].val);
      check("tbl_errors",  seen_err, tbl[i].errs);
      check("tbl_updates", seen_upd, tbl[i].upds);
      check("tbl_echo_len", echo_q.size(), tbl[i].cmd.len());
      ok = (echo_q.size() == tbl[i].cmd.len());
      for (int k = 0; k < echo_q.size() && k < tbl[i].cmd.len(); k++)
        if (echo_q[k] != 8'(tbl[i].cmd[k])) ok = 1'b0;
      check("tbl_echo_bytes", ok, 1'b1);
    end

    // transmitter busy stalls acceptance without losing bytes
    do_reset();
    clear_obs();
    busy_drv = 1'b1;
    rx_q.push_back(8'h72);
    rx_q.push_back(8'h32);
    rx_q.push_back(8'h0A);
    repeat (100) run_cycle();
    check("busy_no_read", seen_rd, 0);
    check("busy_fifo_kept", rx_q.size(), 3);
    busy_drv = 1'b0;
    send("", 3);
    check("busy_reads", seen_rd, 3);
    if (rd_cyc.size() == 3) begin
      check("busy_spacing_1", rd_cyc[1] - rd_cyc[0], 2);
      check("busy_spacing_2", rd_cyc[2] - rd_cyc[1], 2);
    end
    check("busy_led2_r", o_LED2_R, 8'h11);

    // timeout after 50 idle cycles mid-command; trailing LF does nothing
    do_reset();
    send("r1", 0);
    clear_obs();
    repeat (TMO - 1) run_cycle();
    check("tmo_early", seen_err, 0);
    run_cycle();
    check("tmo_fire", seen_err, 1);
    send("\n", 3);
    check("tmo_lf_err", seen_err, 0);
    check("tmo_lf_upd", seen_upd, 0);
    check("tmo_led1_r", o_LED1_R, 8'h00);

    // accept landing on the expiry cycle wins over the timeout
    do_reset();
    send("r1", 0);
    clear_obs();
    repeat (TMO - 1) run_cycle();
    send("\n", 3);
    check("tmo_tie_err", seen_err, 0);
    check("tmo_tie_led", o_LED1_R, 8'h11);

    // reset mid-command discards the partial command
    do_reset();
    send("b2=7", 2);
    do_reset();
    send("b2\n", 3);
    check("rst_mid_led2_b", o_LED2_B, 8'h11);
    check("rst_mid_err", seen_err, 0);

    // randomized traffic with random transmitter stalls and idle gaps
    do_reset();
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 9);
      gen_cmd(kind);
      rand_busy = 1'b1;
      n = 0;
      while (rx_q.size() > 0 && n < 2000) begin
        run_cycle();
        n++;
      end
      check("rand_drain", rx_q.size(), 0);
      rx_q.delete();
      if (kind == 8) repeat ($urandom_range(40, 70)) run_cycle();
      else           repeat ($urandom_range(0, 6)) run_cycle();
    end
    rand_busy = 1'b0;
    repeat (TMO + 5) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
